// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter sharing one slave port.
// Round-robin on ties, one dead cycle between owners, and a stall watchdog that errors the owner.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,

  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,

  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic        granted;
  logic        owner_is1;
  logic        owner_cyc;
  logic        owner_stb;
  logic        stall;
  logic        timeout;
  logic        ack_to_owner;
  logic        err_to_owner;

  assign granted   = (state_q != IDLE) && !wb_rst_i;
  assign owner_is1 = (state_q == GRANT1);

  always_comb begin
    owner_cyc  = owner_is1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    owner_stb  = owner_is1 ? m1_wb_stb_i : m0_wb_stb_i;
    s_wb_we_o  = owner_is1 ? m1_wb_we_i  : m0_wb_we_i;
    s_wb_sel_o = owner_is1 ? m1_wb_sel_i : m0_wb_sel_i;
    s_wb_adr_o = owner_is1 ? m1_wb_adr_i : m0_wb_adr_i;
    s_wb_dat_o = owner_is1 ? m1_wb_dat_i : m0_wb_dat_i;
  end

  assign s_wb_cyc_o = granted && owner_cyc;
  assign s_wb_stb_o = granted && owner_cyc && owner_stb;

  // A slave response in the threshold cycle suppresses the timeout.
  assign stall   = s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i;
  assign timeout = stall && (stall_cnt_q == STALL_LIMIT);

  assign ack_to_owner = granted && s_wb_ack_i;
  assign err_to_owner = granted && (s_wb_err_i || timeout);

  assign m0_wb_ack_o = ack_to_owner && !owner_is1;
  assign m1_wb_ack_o = ack_to_owner && owner_is1;
  assign m0_wb_err_o = err_to_owner && !owner_is1;
  assign m1_wb_err_o = err_to_owner && owner_is1;

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  assign timeout_o = timeout;
  assign grant_o   = wb_rst_i ? 2'b00 : grant_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = (stall && !timeout) ? stall_cnt_q + 16'd1 : 16'd0;

    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d      = last_grant_q ? GRANT0 : GRANT1;
          last_grant_d = !last_grant_q;
        end else if (m0_wb_cyc_i) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end
      end
      GRANT0:  if (!m0_wb_cyc_i) state_d = IDLE;
      GRANT1:  if (!m1_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      GRANT0:  grant_d = 2'b01;
      GRANT1:  grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      stall_cnt_q  <= 16'd0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      grant_q      <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with a 4-cycle watchdog.
// status packs {grant, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, timeout}.
module tb_wb_master_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
  logic [3:0]  m0_wb_sel_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic        m0_wb_ack_o, m0_wb_err_o;
  logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
  logic [3:0]  m1_wb_sel_i;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic        m1_wb_ack_o, m1_wb_err_o;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [3:0]  s_wb_sel_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic        s_wb_ack_i, s_wb_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int vec_count = 0;
  int miss_count = 0;
  logic [8:0] exp_status;

  wire [8:0] status = {grant_o, s_wb_cyc_o, s_wb_stb_o, m0_wb_ack_o, m0_wb_err_o,
                       m1_wb_ack_o, m1_wb_err_o, timeout_o};

  wb_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_sel_i(m0_wb_sel_i), .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i),
    .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_sel_i(m1_wb_sel_i), .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i),
    .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_sel_o(s_wb_sel_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; s_wb_ack_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      vec_count++;
      if (status !== 9'b0) begin
        miss_count++;
        $display("[TB] FAIL reset_hold[%0d]: got %b expected %b", i, status, 9'b0);
      end
      tick();
    end
    wb_rst_i = 1'b0;
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; s_wb_ack_i = 1'b0;
    tick();
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL reset_release: got %b expected %b", status, 9'b0);
    end
  endtask

  task automatic test_single_read();
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_we_i = 1'b0;
    m0_wb_sel_i = 4'hF; m0_wb_adr_i = 32'h0000_0100;
    #1;
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL read_req_cycle: got %b expected %b", status, 9'b0);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin
        s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hA5A5_0001;
      end
      #1;
      exp_status = (c == 3) ? 9'b01_11_1000_0 : 9'b01_11_0000_0;
      vec_count++;
      if (status !== exp_status) begin
        miss_count++;
        $display("[TB] FAIL read_c%0d: got %b expected %b", c, status, exp_status);
      end
    end
    vec_count++;
    if (m0_wb_dat_o !== 32'hA5A5_0001) begin
      miss_count++;
      $display("[TB] FAIL read_data: got %h expected %h", m0_wb_dat_o, 32'hA5A5_0001);
    end
    vec_count++;
    if (s_wb_adr_o !== 32'h0000_0100 || s_wb_sel_o !== 4'hF) begin
      miss_count++;
      $display("[TB] FAIL read_addr: got %h/%h expected %h/%h", s_wb_adr_o, s_wb_sel_o, 32'h100, 4'hF);
    end
    tick();
    s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
    #1;
    vec_count++;
    if (status !== 9'b01_00_0000_0) begin
      miss_count++;
      $display("[TB] FAIL read_drop: got %b expected %b", status, 9'b01_00_0000_0);
    end
    tick();
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL read_idle: got %b expected %b", status, 9'b0);
    end
  endtask

  task automatic test_tie_after_reset();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    m0_wb_adr_i = 32'h0000_0200; m1_wb_adr_i = 32'h0000_0300;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_count++;
      if (status !== 9'b01_10_0000_0) begin
        miss_count++;
        $display("[TB] FAIL tie_m0_first[%0d]: got %b expected %b", i, status, 9'b01_10_0000_0);
      end
    end
    m0_wb_cyc_i = 1'b0;
    tick();
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL tie_dead_cycle: got %b expected %b", status, 9'b0);
    end
    tick();
    vec_count++;
    if (status !== 9'b10_10_0000_0 || s_wb_adr_o !== 32'h0000_0300) begin
      miss_count++;
      $display("[TB] FAIL tie_m1_second: got %b/%h expected %b/%h", status, s_wb_adr_o, 9'b10_10_0000_0, 32'h300);
    end
    m1_wb_cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_grant;
    exp_grant = 2'b01;
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_count++;
      if (grant_o !== exp_grant) begin
        miss_count++;
        $display("[TB] FAIL b2b_grant[%0d]: got %b expected %b", i, grant_o, exp_grant);
      end
      if (exp_grant == 2'b01) m0_wb_cyc_i = 1'b0;
      else                    m1_wb_cyc_i = 1'b0;
      tick();
      vec_count++;
      if (grant_o !== 2'b00) begin
        miss_count++;
        $display("[TB] FAIL b2b_idle[%0d]: got %b expected %b", i, grant_o, 2'b00);
      end
      m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
      exp_grant = {exp_grant[0], exp_grant[1]};
    end
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_we_i = 1'b1; m0_wb_dat_i = 32'h0000_DEAD;
    tick();
    vec_count++;
    if (s_wb_we_o !== 1'b1 || s_wb_dat_o !== 32'h0000_DEAD) begin
      miss_count++;
      $display("[TB] FAIL timeout_wdata: got %b/%h expected %b/%h", s_wb_we_o, s_wb_dat_o, 1'b1, 32'hDEAD);
    end
    for (int k = 1; k <= 8; k++) begin
      exp_status = (k % 4 == 0) ? 9'b01_11_0100_1 : 9'b01_11_0000_0;
      vec_count++;
      if (status !== exp_status) begin
        miss_count++;
        $display("[TB] FAIL timeout_stall%0d: got %b expected %b", k, status, exp_status);
      end
      tick();
    end
    m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; m0_wb_we_i = 1'b0;
    tick();
  endtask

  task automatic test_ack_at_threshold();
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      s_wb_ack_i = (k == 4);
      #1;
      if (k == 4)      exp_status = 9'b10_11_0010_0;
      else if (k == 8) exp_status = 9'b10_11_0001_1;
      else             exp_status = 9'b10_11_0000_0;
      vec_count++;
      if (status !== exp_status) begin
        miss_count++;
        $display("[TB] FAIL ack_thresh%0d: got %b expected %b", k, status, exp_status);
      end
      tick();
    end
    s_wb_ack_i = 1'b0; s_wb_err_i = 1'b1;
    #1;
    vec_count++;
    if (status !== 9'b10_11_0001_0) begin
      miss_count++;
      $display("[TB] FAIL slave_err_pass: got %b expected %b", status, 9'b10_11_0001_0);
    end
    tick();
    s_wb_err_i = 1'b0; m1_wb_stb_i = 1'b0; s_wb_ack_i = 1'b1;
    #1;
    vec_count++;
    if (status !== 9'b10_10_0010_0) begin
      miss_count++;
      $display("[TB] FAIL late_ack_pass: got %b expected %b", status, 9'b10_10_0010_0);
    end
    s_wb_ack_i = 1'b0; m1_wb_cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
    tick();
    vec_count++;
    if (status !== 9'b10_11_0000_0) begin
      miss_count++;
      $display("[TB] FAIL rst_mid_grant: got %b expected %b", status, 9'b10_11_0000_0);
    end
    tick();
    wb_rst_i = 1'b1; s_wb_ack_i = 1'b1;
    #1;
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL rst_mid_during: got %b expected %b", status, 9'b0);
    end
    tick();
    wb_rst_i = 1'b0; s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b1;
    #1;
    vec_count++;
    if (status !== 9'b0) begin
      miss_count++;
      $display("[TB] FAIL rst_mid_after: got %b expected %b", status, 9'b0);
    end
    tick();
    vec_count++;
    if (status !== 9'b01_10_0000_0) begin
      miss_count++;
      $display("[TB] FAIL rst_mid_tie: got %b expected %b", status, 9'b01_10_0000_0);
    end
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    wb_rst_i = 1'b1;
    m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; m0_wb_we_i = 1'b0;
    m0_wb_sel_i = 4'h0; m0_wb_adr_i = '0; m0_wb_dat_i = '0;
    m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0; m1_wb_we_i = 1'b0;
    m1_wb_sel_i = 4'h0; m1_wb_adr_i = '0; m1_wb_dat_i = '0;
    s_wb_dat_i = '0; s_wb_ack_i = 1'b0; s_wb_err_i = 1'b0;

    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_back_to_back();
    test_timeout();
    test_ack_at_threshold();
    test_reset_mid_grant();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
